// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode selectors
// and the pointer-width helper used by the FIFO and its storage array.
package fifo_pkg;

  localparam int FIFO_NORMAL    = 0;
  localparam int FIFO_SHOWAHEAD = 1;

  // Pointers carry one extra wrap bit above the address so that a full
  // FIFO can be told apart from an empty one.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage array for generic_sc_fifo_ext.
// One write port. The read port is either registered (normal mode) or a
// combinational read of the addressed word (show-ahead mode).
module sc_fifo_ram
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int SHOWAHEAD = FIFO_NORMAL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage write; contents are deliberately left uninitialised on reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  if (SHOWAHEAD == FIFO_SHOWAHEAD) begin : g_comb_rd
    // Read port control inputs are not needed when the head word is
    // presented continuously.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst_i | rd_en_i;
    assign rd_data_o = mem[rd_addr_i];
  end else begin : g_reg_rd
    logic [DATA_W-1:0] rd_q;

    // Registered read: captures the popped word on the accepting edge and
    // holds it otherwise. Read-before-write when addresses collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        rd_q <= '0;
      else if (rd_en_i) rd_q <= mem[rd_addr_i];
    end
    assign rd_data_o = rd_q;
  end

endmodule

// File: rtl/generic_sc_fifo_ext.sv
// Single-clock FIFO with selectable normal / show-ahead read mode,
// programmable almost-full / almost-empty thresholds, sticky overflow and
// underflow flags, and a synchronous flush.
module generic_sc_fifo_ext
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int SHOWAHEAD = FIFO_NORMAL,
  parameter int AF_LEVEL  = 2**ADDR_W - 2,
  parameter int AE_LEVEL  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PW = ptr_w(ADDR_W);

  if (ADDR_W < 1 || DATA_W < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL ||
      AF_LEVEL > 2**ADDR_W ||
      (SHOWAHEAD != FIFO_NORMAL && SHOWAHEAD != FIFO_SHOWAHEAD)) begin : g_param_err
    $fatal(1, "generic_sc_fifo_ext: illegal parameter combination");
  end

  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     usedw;
  logic              overflow_q;
  logic              underflow_q;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] ram_rd_data;

  // Occupancy is the modular pointer difference, so it is a pure function
  // of registered state and moves on the same edge as the pointers.
  assign usedw          = wr_ptr_q - rd_ptr_q;
  assign usedw_o        = usedw;
  assign empty_o        = (usedw == '0);
  assign full_o         = usedw[ADDR_W];
  assign almost_empty_o = (int'(usedw) <= AE_LEVEL);
  assign almost_full_o  = (int'(usedw) >= AF_LEVEL);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Accept logic: a write into a full FIFO is allowed when a read frees a
  // slot on the same edge; flush suppresses both operations.
  always_comb begin
    rd_acc = rd_en_i & ~empty_o & ~clr_i;
    wr_acc = wr_en_i & (~full_o | (rd_en_i & ~empty_o)) & ~clr_i;
  end

  // Pointer and sticky error flag state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en_i && full_o && !(rd_en_i && !empty_o)) overflow_q <= 1'b1;
      if (rd_en_i && empty_o) underflow_q <= 1'b1;
    end
  end

  sc_fifo_ram #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SHOWAHEAD (SHOWAHEAD)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (data_i),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (ram_rd_data)
  );

  if (SHOWAHEAD == FIFO_SHOWAHEAD) begin : g_sa_out
    // Memory is not cleared by reset, so the head word is masked while
    // empty to give a defined zero after reset.
    assign data_o = empty_o ? '0 : ram_rd_data;
  end else begin : g_nm_out
    assign data_o = ram_rd_data;
  end

endmodule

// File: tb/tb_generic_sc_fifo_ext.sv
// Directed bench for generic_sc_fifo_ext: one normal-mode and one
// show-ahead instance share the same stimulus and are checked side by side.
module tb_generic_sc_fifo_ext;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  logic [7:0] n_data, s_data;
  logic [5:0] n_usedw, s_usedw;
  logic n_empty, n_full, n_ae, n_af, n_ov, n_un;
  logic s_empty, s_full, s_ae, s_af, s_ov, s_un;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] vals [32];
  logic [7:0] q [$];
  logic [7:0] popped;
  logic [7:0] d;

  always #5 clk = ~clk;

  generic_sc_fifo_ext #(
    .ADDR_W(5), .DATA_W(8), .SHOWAHEAD(0), .AF_LEVEL(30), .AE_LEVEL(2)
  ) u_dut_n (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_en_i(wr_en), .data_i(din),
    .rd_en_i(rd_en), .data_o(n_data), .usedw_o(n_usedw), .empty_o(n_empty),
    .full_o(n_full), .almost_empty_o(n_ae), .almost_full_o(n_af),
    .overflow_o(n_ov), .underflow_o(n_un)
  );

  generic_sc_fifo_ext #(
    .ADDR_W(5), .DATA_W(8), .SHOWAHEAD(1), .AF_LEVEL(30), .AE_LEVEL(2)
  ) u_dut_s (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wr_en_i(wr_en), .data_i(din),
    .rd_en_i(rd_en), .data_o(s_data), .usedw_o(s_usedw), .empty_o(s_empty),
    .full_o(s_full), .almost_empty_o(s_ae), .almost_full_o(s_af),
    .overflow_o(s_ov), .underflow_o(s_un)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cycle(input logic w, input logic [7:0] dd, input logic r, input logic c);
    wr_en = w; din = dd; rd_en = r; clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, " n_usedw"}, 32'(n_usedw), 0);
    check({pfx, " n_empty"}, 32'(n_empty), 1);
    check({pfx, " n_full"},  32'(n_full),  0);
    check({pfx, " n_ae"},    32'(n_ae),    1);
    check({pfx, " n_af"},    32'(n_af),    0);
    check({pfx, " n_ov"},    32'(n_ov),    0);
    check({pfx, " n_un"},    32'(n_un),    0);
    check({pfx, " n_data"},  32'(n_data),  0);
    check({pfx, " s_usedw"}, 32'(s_usedw), 0);
    check({pfx, " s_empty"}, 32'(s_empty), 1);
    check({pfx, " s_ov"},    32'(s_ov),    0);
    check({pfx, " s_data"},  32'(s_data),  0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #12;
    check_reset_state("rst");
    rst = 1'b0;

    // Fill with random bytes, watching occupancy and thresholds.
    for (int i = 0; i < 32; i++) begin
      vals[i] = 8'($urandom);
      cycle(1'b1, vals[i], 1'b0, 1'b0);
      check("fill usedw_n", 32'(n_usedw), 32'(i + 1));
      check("fill usedw_s", 32'(s_usedw), 32'(i + 1));
      if (i == 0) begin
        check("sa first word", 32'(s_data), 32'(vals[0]));
        check("sa not empty", 32'(s_empty), 0);
      end
      if (i == 1) check("ae at 2", 32'(n_ae), 1);
      if (i == 2) check("ae at 3", 32'(n_ae), 0);
      if (i == 28) check("af at 29", 32'(n_af), 0);
      if (i == 29) check("af at 30", 32'(n_af), 1);
    end
    check("full_n", 32'(n_full), 1);
    check("full_s", 32'(s_full), 1);

    // Write into a full FIFO is dropped and flagged.
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_n", 32'(n_ov), 1);
    check("ovf_s", 32'(s_ov), 1);
    check("ovf usedw", 32'(n_usedw), 32);
    check("ovf sa head", 32'(s_data), 32'(vals[0]));

    // Drain: read sequence must match write sequence.
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain n_data", 32'(n_data), 32'(vals[i]));
      if (i < 31) check("drain s_data", 32'(s_data), 32'(vals[i + 1]));
      check("drain usedw", 32'(n_usedw), 32'(31 - i));
    end
    check("drained empty", 32'(n_empty), 1);
    check("drained s_empty", 32'(s_empty), 1);
    check("no unf yet", 32'(n_un), 0);

    // Read on empty sets underflow; normal data_o holds.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_n", 32'(n_un), 1);
    check("unf_s", 32'(s_un), 1);
    check("unf hold data", 32'(n_data), 32'(vals[31]));
    check("ovf sticky", 32'(n_ov), 1);

    // Flush clears both sticky flags; normal data_o unchanged.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr ovf", 32'(n_ov), 0);
    check("clr unf", 32'(n_un), 0);
    check("clr s_unf", 32'(s_un), 0);
    check("clr hold data", 32'(n_data), 32'(vals[31]));

    // Show-ahead: single word appears without a read.
    cycle(1'b1, 8'h5C, 1'b0, 1'b0);
    check("sa5c empty", 32'(s_empty), 0);
    check("sa5c data", 32'(s_data), 32'h5C);
    check("sa5c usedw", 32'(s_usedw), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("sa5c pop empty", 32'(s_empty), 1);
    check("nm5c data", 32'(n_data), 32'h5C);
    check("nm5c no unf", 32'(n_un), 0);

    // Full FIFO with simultaneous read/write across pointer wrap.
    for (int i = 0; i < 32; i++) begin
      d = 8'(i * 9 + 1);
      q.push_back(d);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    for (int k = 0; k < 40; k++) begin
      d = 8'(128 + k * 3);
      popped = q.pop_front();
      q.push_back(d);
      cycle(1'b1, d, 1'b1, 1'b0);
      check("rw n_data", 32'(n_data), 32'(popped));
      check("rw s_data", 32'(s_data), 32'(q[0]));
      check("rw usedw", 32'(n_usedw), 32);
      check("rw full", 32'(n_full), 1);
      check("rw no ovf", 32'(n_ov), 0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr2 empty", 32'(n_empty), 1);

    // Flush wins over a same-cycle write.
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(64 + i), 1'b0, 1'b0);
    check("17 usedw", 32'(n_usedw), 17);
    cycle(1'b1, 8'h11, 1'b0, 1'b1);
    check("clrwr usedw_n", 32'(n_usedw), 0);
    check("clrwr usedw_s", 32'(s_usedw), 0);
    check("clrwr empty", 32'(n_empty), 1);
    check("clrwr hold", 32'(n_data), 32'(popped));
    cycle(1'b1, 8'h3E, 1'b0, 1'b0);
    check("new sa data", 32'(s_data), 32'h3E);
    check("new usedw", 32'(n_usedw), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("new n_data", 32'(n_data), 32'h3E);
    check("new empty", 32'(n_empty), 1);

    // Read+write on empty: read ignored and flagged, write accepted.
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("rwe unf", 32'(n_un), 1);
    check("rwe usedw", 32'(n_usedw), 1);
    check("rwe sa data", 32'(s_data), 32'h77);
    check("rwe n hold", 32'(n_data), 32'h3E);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Fill, overflow, then asynchronous reset between edges.
    for (int i = 0; i < 33; i++) cycle(1'b1, 8'(200 + i), 1'b0, 1'b0);
    check("pre-rst ovf", 32'(n_ov), 1);
    check("pre-rst af", 32'(n_af), 1);
    rst = 1'b1;
    #2;
    check_reset_state("async rst");
    rst = 1'b0;
    cycle(1'b1, 8'h9D, 1'b0, 1'b0);
    check("post-rst sa data", 32'(s_data), 32'h9D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
